// File: rtl/ipf_feeder.sv
// ipf_feeder: job sequencer that streams weight rows, then replays the input
// tile once per weight pass, then drains with hold and signals end to IPF.
module ipf_feeder #(
  parameter int unsigned D_W       = 512,
  parameter int unsigned DRAIN_CYC = 10,
  parameter int unsigned FMT       = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [1:0]     cmd_wsize,
  input  logic           cmd_stride,
  output logic           w_rd_en,
  output logic [4:0]     w_rd_addr,
  input  logic [D_W-1:0] w_rd_data,
  output logic           i_rd_en,
  output logic [2:0]     i_rd_addr,
  input  logic [D_W-1:0] i_rd_data,
  output logic [1:0]     ctrl,
  output logic           w_valid,
  output logic [D_W-1:0] w_data,
  output logic           i_valid,
  output logic [D_W-1:0] i_data,
  output logic [1:0]     Wsize,
  output logic           stride,
  output logic [3:0]     wgroup,
  output logic [2:0]     wround,
  output logic [1:0]     RLPadding,
  output logic [3:0]     i_format,
  output logic [3:0]     w_format,
  output logic           busy,
  output logic           done
);

  localparam int unsigned CNT_W = 5;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);
  localparam logic [1:0] CTRL_END   = 2'd0;
  localparam logic [1:0] CTRL_START = 2'd1;
  localparam logic [1:0] CTRL_HOLD  = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_PASS, S_DRAIN, S_END} state_t;

  // sequencer state
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       pass_q, pass_d;
  logic [1:0]       wsize_q, wsize_d;
  logic             stride_q, stride_d;
  logic             busy_q, busy_d;
  logic             cmd_ready_q, cmd_ready_d;

  // issue stage (memory request plus the sideband that travels with it)
  logic             w_rd_en_q, w_rd_en_d;
  logic [4:0]       w_rd_addr_q, w_rd_addr_d;
  logic             i_rd_en_q, i_rd_en_d;
  logic [2:0]       i_rd_addr_q, i_rd_addr_d;
  logic [1:0]       ctrl_s0_q, ctrl_s0_d;
  logic [3:0]       wg_s0_q, wg_s0_d;
  logic [2:0]       wr_s0_q, wr_s0_d;
  logic             end_s0_q, end_s0_d;

  // stage 1, aligned with memory read data
  logic             wv_s1_q, wv_s1_d;
  logic             iv_s1_q, iv_s1_d;
  logic [1:0]       ctrl_s1_q, ctrl_s1_d;
  logic [3:0]       wg_s1_q, wg_s1_d;
  logic [2:0]       wr_s1_q, wr_s1_d;
  logic             end_s1_q, end_s1_d;

  // stage 2, the IPF-facing outputs
  logic             w_valid_q, w_valid_d;
  logic [D_W-1:0]   w_data_q, w_data_d;
  logic             i_valid_q, i_valid_d;
  logic [D_W-1:0]   i_data_q, i_data_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic [3:0]       wgroup_q, wgroup_d;
  logic [2:0]       wround_q, wround_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] nw_last_c;
  logic [1:0]       np_last_c;
  logic [2:0]       pre_c;

  // job constants from the latched configuration
  always_comb begin
    nw_last_c = CNT_W'(24);
    np_last_c = 2'd3;
    pre_c     = 3'd6;
    unique case (wsize_q)
      2'd0: begin
        nw_last_c = CNT_W'(17);
        np_last_c = stride_q ? 2'd0 : 2'd1;
        pre_c     = 3'd2;
      end
      2'd1: begin
        nw_last_c = CNT_W'(24);
        np_last_c = 2'd1;
        pre_c     = 3'd4;
      end
      default: begin
        nw_last_c = CNT_W'(24);
        np_last_c = 2'd3;
        pre_c     = 3'd6;
      end
    endcase
  end

  // next-state and counter sequencing
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pass_d   = pass_q;
    wsize_d  = wsize_q;
    stride_d = stride_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d  = S_LOAD_W;
          cnt_d    = '0;
          pass_d   = '0;
          wsize_d  = (cmd_wsize == 2'd3) ? 2'd2 : cmd_wsize;
          stride_d = cmd_stride;
        end
      end
      S_LOAD_W: begin
        if (cnt_q == nw_last_c) begin
          state_d = S_PASS;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PASS: begin
        if (cnt_q == CNT_W'(15)) begin
          cnt_d = '0;
          if (pass_q == np_last_c) state_d = S_DRAIN;
          else                     pass_d  = pass_q + 2'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = S_END;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_END: begin
        // end marker issued on the first cycle; two more cycles let it reach IPF
        if (cnt_q == CNT_W'(2)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // issue-stage decode from the upcoming state so every port is a flop
  always_comb begin
    busy_d      = (state_d != S_IDLE);
    cmd_ready_d = (state_d == S_IDLE);
    w_rd_en_d   = (state_d == S_LOAD_W);
    w_rd_addr_d = w_rd_en_d ? cnt_d : w_rd_addr_q;
    i_rd_en_d   = (state_d == S_PASS);
    i_rd_addr_d = i_rd_en_d ? cnt_d[2:0] : i_rd_addr_q;
    ctrl_s0_d   = CTRL_END;
    wg_s0_d     = wg_s0_q;
    wr_s0_d     = wr_s0_q;
    end_s0_d    = 1'b0;
    unique case (state_d)
      S_LOAD_W: ctrl_s0_d = CTRL_HOLD;
      S_PASS: begin
        ctrl_s0_d = (cnt_d < CNT_W'(pre_c)) ? CTRL_HOLD : CTRL_START;
        wr_s0_d   = (wsize_q == 2'd0) ? 3'd0 : {1'b0, pass_d};
        if (!stride_q) begin
          wg_s0_d = (wsize_q == 2'd0) ? {2'b00, pass_d} : 4'd0;
        end else if (cnt_d == CNT_W'(pre_c)) begin
          wg_s0_d = 4'd0;
        end else if (cnt_d > CNT_W'(pre_c)) begin
          wg_s0_d = {3'b000, ~wg_s0_q[0]};
        end
      end
      S_DRAIN: ctrl_s0_d = CTRL_HOLD;
      S_END: begin
        ctrl_s0_d = CTRL_END;
        end_s0_d  = (cnt_d == '0);
      end
      default: ctrl_s0_d = CTRL_END;
    endcase
  end

  // two-stage alignment pipeline; data registers hold while invalid
  always_comb begin
    wv_s1_d   = w_rd_en_q;
    iv_s1_d   = i_rd_en_q;
    ctrl_s1_d = ctrl_s0_q;
    wg_s1_d   = wg_s0_q;
    wr_s1_d   = wr_s0_q;
    end_s1_d  = end_s0_q;
    w_valid_d = wv_s1_q;
    w_data_d  = wv_s1_q ? w_rd_data : w_data_q;
    i_valid_d = iv_s1_q;
    i_data_d  = iv_s1_q ? i_rd_data : i_data_q;
    ctrl_d    = ctrl_s1_q;
    wgroup_d  = wg_s1_q;
    wround_d  = wr_s1_q;
    done_d    = end_s1_q;
  end

  // all state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pass_q      <= '0;
      wsize_q     <= '0;
      stride_q    <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      w_rd_en_q   <= 1'b0;
      w_rd_addr_q <= '0;
      i_rd_en_q   <= 1'b0;
      i_rd_addr_q <= '0;
      ctrl_s0_q   <= '0;
      wg_s0_q     <= '0;
      wr_s0_q     <= '0;
      end_s0_q    <= 1'b0;
      wv_s1_q     <= 1'b0;
      iv_s1_q     <= 1'b0;
      ctrl_s1_q   <= '0;
      wg_s1_q     <= '0;
      wr_s1_q     <= '0;
      end_s1_q    <= 1'b0;
      w_valid_q   <= 1'b0;
      w_data_q    <= '0;
      i_valid_q   <= 1'b0;
      i_data_q    <= '0;
      ctrl_q      <= '0;
      wgroup_q    <= '0;
      wround_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pass_q      <= pass_d;
      wsize_q     <= wsize_d;
      stride_q    <= stride_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
      w_rd_en_q   <= w_rd_en_d;
      w_rd_addr_q <= w_rd_addr_d;
      i_rd_en_q   <= i_rd_en_d;
      i_rd_addr_q <= i_rd_addr_d;
      ctrl_s0_q   <= ctrl_s0_d;
      wg_s0_q     <= wg_s0_d;
      wr_s0_q     <= wr_s0_d;
      end_s0_q    <= end_s0_d;
      wv_s1_q     <= wv_s1_d;
      iv_s1_q     <= iv_s1_d;
      ctrl_s1_q   <= ctrl_s1_d;
      wg_s1_q     <= wg_s1_d;
      wr_s1_q     <= wr_s1_d;
      end_s1_q    <= end_s1_d;
      w_valid_q   <= w_valid_d;
      w_data_q    <= w_data_d;
      i_valid_q   <= i_valid_d;
      i_data_q    <= i_data_d;
      ctrl_q      <= ctrl_d;
      wgroup_q    <= wgroup_d;
      wround_q    <= wround_d;
      done_q      <= done_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign w_rd_en   = w_rd_en_q;
  assign w_rd_addr = w_rd_addr_q;
  assign i_rd_en   = i_rd_en_q;
  assign i_rd_addr = i_rd_addr_q;
  assign ctrl      = ctrl_q;
  assign w_valid   = w_valid_q;
  assign w_data    = w_data_q;
  assign i_valid   = i_valid_q;
  assign i_data    = i_data_q;
  assign Wsize     = wsize_q;
  assign stride    = stride_q;
  assign wgroup    = wgroup_q;
  assign wround    = wround_q;
  assign RLPadding = 2'b00;
  assign i_format  = 4'(FMT);
  assign w_format  = 4'(FMT);

endmodule

// File: doc/ipf_feeder.md
Name: ipf_feeder

Overview:
- Upstream sequencer for the IPF convolution engine.
- On a job command it does three things in order:
  - reads weight rows from a weight buffer and streams them to IPF with w_valid;
  - replays the 8-row input tile from an input buffer once per weight pass, driving ctrl, wgroup and wround;
  - drains with hold, then issues end.
- It replaces the hand-written stimulus schedule, so IPF can run from on-chip buffers.

Parameters:
- D_W, 512, width of input and weight rows.
- DRAIN_CYC, 10, number of ctrl=hold cycles after the last pass.
- FMT, 2, constant value driven on i_format and w_format.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  job request
- cmd_ready  out  1  feeder idle; a job is accepted when cmd_valid && cmd_ready
- cmd_wsize  in  2  0=3x3, 1=5x5, 2=7x7 (3 is illegal and is treated as 2)
- cmd_stride  in  1  0=stride 1, 1=stride 2
- w_rd_en / w_rd_addr  out  1 / 5  weight buffer read; data returns 1 cycle later
- w_rd_data  in  D_W  weight buffer read data
- i_rd_en / i_rd_addr  out  1 / 3  input buffer read; data returns 1 cycle later
- i_rd_data  in  D_W  input buffer read data
- ctrl  out  2  to IPF: 0=end, 1=start, 2=hold
- w_valid, w_data  out  1, D_W  to IPF
- i_valid, i_data  out  1, D_W  to IPF
- Wsize, stride  out  2, 1  latched job configuration
- wgroup  out  4  to IPF
- wround  out  3  to IPF
- RLPadding  out  2  tied to 0
- i_format, w_format  out  4  = FMT
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end

Behaviour:
- Reset values:
  - all outputs 0, except cmd_ready=1 and i_format/w_format=FMT.
  - state IDLE.
  - Reset mid-job aborts immediately; no done pulse is produced.
- Job acceptance:
  - in IDLE, cmd_valid&&cmd_ready latches cmd_wsize and cmd_stride into Wsize and stride.
  - busy=1 and cmd_ready=0 from the next cycle until done.
  - cmd_valid while busy is ignored.
- Derived job constants:
  - NW (weight rows) = 18 if Wsize=0, else 25.
  - PRE = 2, 4, 6 for Wsize 0, 1, 2.
  - NP (passes): Wsize0 → 2 if stride=0, else 1; Wsize1 → 2; Wsize2 → 4.
- States: IDLE → LOAD_W → PASS → DRAIN → END → IDLE.
- LOAD_W:
  - issue w_rd_addr 0..NW-1 on consecutive cycles, w_rd_en=1.
- PASS (runs NP times):
  - issue i_rd_addr 0..7, then 0..7 again: 16 consecutive reads, i_rd_en=1.
  - Pass p, stride=0: wgroup=(Wsize==0)?p:0 and wround=(Wsize==0)?0:p.
  - Pass p, stride=1: wround=(Wsize==0)?0:p. wgroup resets to 0 at the first ctrl=1 row of each pass and toggles on every subsequent row.
  - Within a pass, rows 0..PRE-1 carry ctrl=2 (hold) and rows PRE..15 carry ctrl=1.
  - Passes run back-to-back with no gap cycles.
- DRAIN: DRAIN_CYC cycles with ctrl=2, i_valid=0, w_valid=0.
- END:
  - one cycle with ctrl=0 and done=1.
  - next cycle returns to IDLE with cmd_ready=1.
- Output timing:
  - every outputted row is registered, so a memory read issued in cycle t appears on w_data/i_data in cycle t+2.
  - ctrl, wgroup, wround, w_valid and i_valid travel through the same 2-stage pipeline, so they stay aligned with their data.
  - DRAIN/END ctrl values enter the same pipeline, so IPF never sees hold/end before the last row.
- Hold behaviour:
  - w_data and i_data hold their last value while the corresponding valid is 0.
  - in IDLE, ctrl is 0 and wgroup/wround keep their last value.
- Address sequencing: addresses wrap 7→0 on the input buffer only. The weight address never exceeds NW-1.

Test Plan:
- Reset / idle: reset with cmd_valid=0 → all outputs 0, cmd_ready=1. Pulse rst_n low during PASS → outputs return to 0 asynchronously; no done pulse.
- 3x3 stride1 job (wsize=0, stride=0):
  - exactly 18 w_valid cycles with w_data = weight rows 0..17;
  - then 32 i_valid cycles with rows 0..7,0..7,0..7,0..7;
  - ctrl pattern per pass = 2,2 followed by fourteen 1s; wgroup=0 for pass 0, then 1;
  - then 10 hold cycles, 1 end cycle, done; total 18+32+10+1 cycles after the first output.
- 3x3 stride2 job (wsize=0, stride=1): single pass of 16 rows; on ctrl=1 rows wgroup = 0,1,0,1,…; wround=0 throughout.
- 7x7 stride1 job (wsize=2, stride=0): 25 weight rows; 4 passes with wround 0,1,2,3; each pass has 6 hold rows then 10 start rows.
- Back-to-back jobs:
  - cmd_valid held high through a job → second job accepted only in the IDLE cycle after done.
  - cmd_valid asserted during busy is ignored (exactly one done per accepted command).
- Memory latency alignment: return distinct patterns from the memory model (row index in bits [7:0]) → every i_data/w_data carries the expected index in the same cycle as its valid and ctrl values.
